// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory.
// Assembles a little-endian byte stream into 32-bit words and writes them
// to consecutive word addresses starting at 0. The core is held stalled
// until the requested number of words is resident.
module imem_boot_loader #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW:0]   word_count,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_waddr,
   output logic [31:0]   imem_wdata,
   output logic          core_stall,
   output logic          load_busy,
   output logic          load_done,
   output logic          cfg_err
);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   localparam logic [AW:0] MAX_WC = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic [AW:0]   wcnt_q, wcnt_d;     // latched number of words to load
   logic [AW-1:0] widx_q, widx_d;     // word currently being assembled
   logic [1:0]    bidx_q, bidx_d;     // next byte lane within the word
   logic [31:0]   asm_q, asm_d;       // word assembly register
   logic          cfg_err_q, cfg_err_d;

   // Next-state logic: start handling, byte assembly and word sequencing.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      widx_d    = widx_q;
      bidx_d    = bidx_q;
      asm_d     = asm_q;
      cfg_err_d = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               if (word_count == '0) begin
                  state_d = DONE;
               end else if (word_count > MAX_WC) begin
                  // Rejected request leaves the current state untouched.
                  cfg_err_d = 1'b1;
               end else begin
                  state_d = RECV;
                  wcnt_d  = word_count;
                  widx_d  = '0;
                  bidx_d  = '0;
                  asm_d   = '0;
               end
            end
         end
         RECV: begin
            // byte_ready is high throughout RECV, so valid alone means a handshake.
            if (byte_valid) begin
               asm_d[8*bidx_q +: 8] = byte_data;
               bidx_d               = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (({1'b0, widx_q} + (AW+1)'(1)) == wcnt_q) begin
               state_d = DONE;
            end else begin
               widx_d  = widx_q + AW'(1);
               bidx_d  = '0;
               state_d = RECV;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset aborts any load in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wcnt_q    <= '0;
         widx_q    <= '0;
         bidx_q    <= '0;
         asm_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         widx_q    <= widx_d;
         bidx_q    <= bidx_d;
         asm_q     <= asm_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // All outputs decode straight from registered state.
   assign byte_ready = (state_q == RECV);
   assign imem_we    = (state_q == WRITE);
   assign imem_waddr = widx_q;
   assign imem_wdata = asm_q;
   assign core_stall = (state_q != DONE);
   assign load_busy  = (state_q == RECV) || (state_q == WRITE);
   assign load_done  = (state_q == DONE);
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: per-cycle vector table plus a
// reset check and a handshake-driven load with a bounded wait.
module tb_imem_boot_loader;

   localparam int S_I = 0, S_R = 1, S_W = 2, S_D = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  word_count = '0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_ready, imem_we, core_stall, load_busy, load_done, cfg_err;
   logic [7:0]  imem_waddr;
   logic [31:0] imem_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit          r;
      bit          st;
      logic [8:0]  wc;
      bit          bv;
      logic [7:0]  bd;
      int          s;
      logic [7:0]  a;
      logic [31:0] d;
      bit          e;
   } vec_t;

   vec_t vecs[$];

   imem_boot_loader #(.DEPTH(256), .AW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .word_count(word_count),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .core_stall(core_stall), .load_busy(load_busy), .load_done(load_done),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic add(input bit r, input bit st, input logic [8:0] wc, input bit bv,
                      input logic [7:0] bd, input int s, input logic [7:0] a,
                      input logic [31:0] d, input bit e);
      vec_t v;
      v.r = r; v.st = st; v.wc = wc; v.bv = bv; v.bd = bd;
      v.s = s; v.a = a; v.d = d; v.e = e;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // byte stream helpers
   task automatic rb(input logic [7:0] b);
      add(0, 0, 0, 1, b, S_R, 0, 0, 0);
   endtask

   initial begin
      logic [45:0] ev, av;
      logic [7:0]  bytes [4];
      int          bi;
      bit          seen;

      // idle after reset
      for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 8'h00, S_I, 0, 0, 0);
      // load of two words, valid held high (data held during WRITE)
      add(0, 1, 9'd2, 0, 8'h00, S_I, 0, 0, 0);
      rb(8'h13); rb(8'h05); rb(8'h50); rb(8'h00);
      add(0, 0, 0, 1, 8'h93, S_W, 8'd0, 32'h00500513, 0);
      rb(8'h93); rb(8'h05); rb(8'hA0); rb(8'h00);
      add(0, 0, 0, 0, 8'h00, S_W, 8'd1, 32'h00A00593, 0);
      add(0, 0, 0, 0, 8'h00, S_D, 0, 0, 0);
      // reload from DONE with byte_valid toggling every cycle
      add(0, 1, 9'd2, 0, 8'h00, S_D, 0, 0, 0);
      rb(8'h13); add(0, 0, 0, 0, 8'hAA, S_R, 0, 0, 0);
      rb(8'h05); add(0, 0, 0, 0, 8'hAA, S_R, 0, 0, 0);
      rb(8'h50); add(0, 0, 0, 0, 8'hAA, S_R, 0, 0, 0);
      rb(8'h00);
      add(0, 0, 0, 0, 8'hAA, S_W, 8'd0, 32'h00500513, 0);
      rb(8'h93); add(0, 0, 0, 0, 8'hAA, S_R, 0, 0, 0);
      rb(8'h05); add(0, 0, 0, 0, 8'hAA, S_R, 0, 0, 0);
      rb(8'hA0); add(0, 0, 0, 0, 8'hAA, S_R, 0, 0, 0);
      rb(8'h00);
      add(0, 0, 0, 0, 8'hAA, S_W, 8'd1, 32'h00A00593, 0);
      // reset from DONE, then oversize start rejected, then zero-length load
      add(1, 0, 0, 0, 8'h00, S_D, 0, 0, 0);
      add(0, 1, 9'd257, 0, 8'h00, S_I, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00, S_I, 0, 0, 1);
      add(0, 1, 9'd0, 0, 8'h00, S_I, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00, S_D, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00, S_D, 0, 0, 0);
      // three-word load aborted by reset after two bytes of word 1
      add(0, 1, 9'd3, 0, 8'h00, S_D, 0, 0, 0);
      rb(8'h11); rb(8'h22); rb(8'h33); rb(8'h44);
      add(0, 0, 0, 0, 8'h00, S_W, 8'd0, 32'h44332211, 0);
      rb(8'h55); rb(8'h66);
      add(1, 0, 0, 1, 8'h77, S_R, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00, S_I, 0, 0, 0);
      // fresh load restarts at address 0
      add(0, 1, 9'd1, 0, 8'h00, S_I, 0, 0, 0);
      rb(8'h01); rb(8'h02); rb(8'h03); rb(8'h04);
      add(0, 0, 0, 0, 8'h00, S_W, 8'd0, 32'h04030201, 0);
      // reload from DONE; a start during RECV is ignored
      add(0, 1, 9'd1, 0, 8'h00, S_D, 0, 0, 0);
      rb(8'hEF);
      add(0, 1, 9'd257, 1, 8'hBE, S_R, 0, 0, 0);
      rb(8'hAD); rb(8'hDE);
      add(0, 0, 0, 0, 8'h00, S_W, 8'd0, 32'hDEADBEEF, 0);
      // DEPTH words is a legal request
      add(0, 1, 9'd256, 0, 8'h00, S_D, 0, 0, 0);
      add(1, 0, 0, 0, 8'h00, S_R, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00, S_I, 0, 0, 0);

      // reset held for two edges
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ctl", {58'b0, byte_ready, imem_we, core_stall, load_done, load_busy, cfg_err},
          {58'b0, 6'b001000});
      chk("rst_addr", {56'b0, imem_waddr}, 64'h0);
      chk("rst_data", {32'b0, imem_wdata}, 64'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].r; start = vecs[i].st; word_count = vecs[i].wc;
         byte_valid = vecs[i].bv; byte_data = vecs[i].bd;
         ev = {vecs[i].s == S_R, vecs[i].s == S_W, vecs[i].s != S_D, vecs[i].s == S_D,
               vecs[i].s == S_R || vecs[i].s == S_W, vecs[i].e,
               (vecs[i].s == S_W) ? vecs[i].a : 8'h0,
               (vecs[i].s == S_W) ? vecs[i].d : 32'h0};
         av = {byte_ready, imem_we, core_stall, load_done, load_busy, cfg_err,
               (vecs[i].s == S_W) ? imem_waddr : 8'h0,
               (vecs[i].s == S_W) ? imem_wdata : 32'h0};
         chk($sformatf("vec%0d", i), {18'b0, av}, {18'b0, ev});
      end

      // handshake-driven single-word load with a bounded wait for the write
      @(negedge clk);
      rst = 1'b0; byte_valid = 1'b0; start = 1'b1; word_count = 9'd1;
      bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
      bi = 0; seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (imem_we) begin
            seen = 1'b1;
            byte_valid = 1'b0;
            chk("hs_addr", {56'b0, imem_waddr}, 64'h0);
            chk("hs_data", {32'b0, imem_wdata}, 64'h12345678);
         end else if (byte_ready && bi < 4) begin
            byte_valid = 1'b1;
            byte_data  = bytes[bi];
            bi++;
         end
      end
      chk("hs_write_seen", {63'b0, seen}, 64'h1);
      @(negedge clk);
      chk("hs_done", {62'b0, load_done, core_stall}, 64'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
